// File: rtl/dual_issue_sequencer_pkg.sv
// Shared decode constants, FSM state type and register-use decode for the dual-issue sequencer.
package dual_issue_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  typedef enum logic {IDLE, SPLIT} seq_state_e;

  typedef struct packed {
    logic       wr;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_use_t;

  // f holds the low instruction bits up to rs2; nz flags a non-NOP word.
  function automatic instr_use_t decode_use(input logic [RS2_MSB:0] f, input logic nz);
    instr_use_t u;
    logic [6:0] opc;
    opc       = f[OPC_MSB:OPC_LSB];
    u.rd      = f[RD_MSB:RD_LSB];
    u.rs1     = f[RS1_MSB:RS1_LSB];
    u.rs2     = f[RS2_MSB:RS2_LSB];
    u.wr      = nz && (u.rd != 5'd0) &&
                (opc == OP_RTYPE || opc == OP_ITYPE || opc == OP_LUI);
    u.use_rs1 = (opc == OP_RTYPE) || (opc == OP_ITYPE);
    u.use_rs2 = (opc == OP_RTYPE);
    return u;
  endfunction

endpackage

// File: rtl/dual_issue_sequencer_hazard.sv
// Combinational intra-pair RAW/WAW detector; x0 destinations never create a hazard.
module pair_hazard_detect
  import dual_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr0,
  input  logic [XLEN-1:0] instr1,
  output logic            hazard,
  output logic            raw,
  output logic            waw
);

  instr_use_t u0, u1;
  logic       nz1;

  assign u0  = decode_use(instr0[RS2_MSB:0], |instr0);
  assign u1  = decode_use(instr1[RS2_MSB:0], |instr1);
  assign nz1 = |instr1;

  // u0.wr already excludes rd0 == x0, so matching x0 sources cannot fire.
  assign raw    = u0.wr && nz1 &&
                  ((u1.use_rs1 && (u1.rs1 == u0.rd)) || (u1.use_rs2 && (u1.rs2 == u0.rd)));
  assign waw    = u0.wr && nz1 && u1.wr && (u1.rd == u0.rd);
  assign hazard = raw || waw;

endmodule

// File: rtl/dual_issue_sequencer.sv
// Dual-issue pair sequencer: issues independent pairs together, splits dependent pairs over two cycles.
// Optional perf counters (pair_cnt, split_cnt) are built when DUAL_ISSUE_PERF_EN is defined.
module dual_issue_sequencer
  import dual_issue_pkg::*;
#(
  parameter int XLEN = 32
`ifdef DUAL_ISSUE_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            pair_valid,
  input  logic [XLEN-1:0] instr0,
  input  logic [XLEN-1:0] instr1,
  input  logic            stall,
  output logic            pair_ready,
  output logic            dp1_en,
  output logic            dp2_en,
  output logic [XLEN-1:0] dp1_instr,
  output logic [XLEN-1:0] dp2_instr,
  output logic            freeze1,
  output logic            freeze2,
  output logic            split_active
`ifdef DUAL_ISSUE_PERF_EN
  , output logic [CNT_W-1:0] pair_cnt
  , output logic [CNT_W-1:0] split_cnt
`endif
);

  seq_state_e            state, nxt_state;
  logic [1:0]            en_q, nxt_en;
  logic [1:0][XLEN-1:0]  instr_q, nxt_instr;
  logic                  hazard, raw, waw;
  logic                  split_evt;

  pair_hazard_detect #(.XLEN(XLEN)) u_hzd (
    .instr0 (instr0),
    .instr1 (instr1),
    .hazard (hazard),
    .raw    (raw),
    .waw    (waw)
  );

  always_comb begin
    nxt_state  = state;
    nxt_en     = en_q;
    nxt_instr  = instr_q;
    pair_ready = 1'b0;
    split_evt  = 1'b0;
    if (!stall) begin
      nxt_en = 2'b00;
      case (state)
        IDLE: if (pair_valid) begin
          nxt_instr[0] = instr0;
          if (hazard) begin
            nxt_en    = 2'b01;
            nxt_state = SPLIT;
            split_evt = 1'b1;
          end else begin
            pair_ready   = 1'b1;
            nxt_en       = {|instr1, |instr0};
            nxt_instr[1] = instr1;
          end
        end
        SPLIT: begin
          // Pop happens here; a dropped pair_valid simply abandons slot 1.
          pair_ready = 1'b1;
          nxt_state  = IDLE;
          if (pair_valid) begin
            nxt_en       = 2'b10;
            nxt_instr[1] = instr1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= nxt_state;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      en_q    <= '0;
      instr_q <= '0;
    end else begin
      en_q    <= nxt_en;
      instr_q <= nxt_instr;
    end
  end

  assign dp1_en       = en_q[0];
  assign dp2_en       = en_q[1];
  assign dp1_instr    = instr_q[0];
  assign dp2_instr    = instr_q[1];
  assign freeze1      = ~en_q[0];
  assign freeze2      = ~en_q[1];
  assign split_active = (state == SPLIT);

`ifdef DUAL_ISSUE_PERF_EN
  logic pop;
  assign pop = pair_valid && pair_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pair_cnt  <= '0;
      split_cnt <= '0;
    end else begin
      if (pop && (pair_cnt != '1))        pair_cnt  <= pair_cnt + CNT_W'(1);
      if (split_evt && (split_cnt != '1)) split_cnt <= split_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
